// File: rtl/spi_slave.sv
// SPI responder: synchronizes pins into i_clk, shifts MOSI in on SCLK rise,
// drives MISO on SCLK fall, and hands each full frame to the client.
module spi_slave #(
  parameter int BITS        = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [BITS-1:0] i_data,
  input  logic            i_load,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err,
  input  logic            i_sclk,
  input  logic            i_ss,
  input  logic            i_mosi,
  output logic            o_miso
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic sclk_d;
  logic ss_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;
  logic last_rise;

  logic [BITS-1:0] tx_buf, tx_buf_n;
  logic [BITS-1:0] tx_sh, tx_sh_n;
  logic [BITS-1:0] rx_sh, rx_sh_n;
  logic [BITS-1:0] rx_new;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [BITS-1:0] data_n;
  logic            valid_n, busy_n, err_n, miso_n;

  // Synchronizers idle at sclk=0, ss=1, mosi=0
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], i_sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], i_ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      ss_d   <= ss_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign cnt_inc   = (cnt == CW'(BITS)) ? cnt : cnt + 1'b1;
  assign rx_new    = {rx_sh[BITS-2:0], mosi_s};
  assign last_rise = sclk_rise && (cnt == CW'(BITS - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) state_n = SHIFT;
      end
      SHIFT: begin
        if (last_rise) state_n = ss_rise ? IDLE : DONE;
        else if (ss_rise) state_n = IDLE;
      end
      DONE: begin
        if (ss_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_buf_n = i_load ? i_data : tx_buf;
    tx_sh_n  = tx_sh;
    rx_sh_n  = rx_sh;
    cnt_n    = cnt;
    data_n   = o_data;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    busy_n   = o_busy;
    miso_n   = o_miso;
    unique case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        miso_n = 1'b0;
        // The registered buffer is used, so a same-cycle load waits a frame
        if (ss_fall) begin
          tx_sh_n = tx_buf;
          miso_n  = tx_buf[BITS-1];
          rx_sh_n = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_sh_n = rx_new;
          cnt_n   = cnt_inc;
        end
        if (last_rise) begin
          data_n  = rx_new;
          valid_n = 1'b1;
          if (ss_rise) begin
            busy_n = 1'b0;
            miso_n = 1'b0;
          end
        end else if (ss_rise) begin
          err_n  = 1'b1;
          busy_n = 1'b0;
          miso_n = 1'b0;
        end else if (sclk_fall) begin
          tx_sh_n = {tx_sh[BITS-2:0], 1'b0};
          miso_n  = tx_sh[BITS-2];
        end
      end
      DONE: begin
        busy_n = 1'b1;
        if (ss_rise) begin
          busy_n = 1'b0;
          miso_n = 1'b0;
        end
      end
      default: begin
        busy_n = 1'b0;
        miso_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_buf  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      cnt     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
      o_miso  <= 1'b0;
    end else begin
      tx_buf  <= tx_buf_n;
      tx_sh   <= tx_sh_n;
      rx_sh   <= rx_sh_n;
      cnt     <= cnt_n;
      o_data  <= data_n;
      o_valid <= valid_n;
      o_err   <= err_n;
      o_busy  <= busy_n;
      o_miso  <= miso_n;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of SPI frames plus
// hand sequences for reset abort and SS-idle activity.
module tb_spi_slave;

  localparam int BITS = 20;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [BITS-1:0] i_data = '0;
  logic            i_load = 1'b0;
  logic [BITS-1:0] o_data;
  logic            o_valid;
  logic            o_busy;
  logic            o_err;
  logic            i_sclk = 1'b0;
  logic            i_ss = 1'b1;
  logic            i_mosi = 1'b0;
  logic            o_miso;

  spi_slave #(.BITS(BITS), .SYNC_STAGES(2)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_load (i_load),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_busy (o_busy),
    .o_err  (o_err),
    .i_sclk (i_sclk),
    .i_ss   (i_ss),
    .i_mosi (i_mosi),
    .o_miso (o_miso)
  );

  always #5 i_clk = ~i_clk;

  int vecs = 0;
  int miss = 0;
  int nvalid = 0;
  int nerr = 0;
  int nboth = 0;
  int nlong = 0;
  int nbusy = 0;
  int nmiso = 0;
  logic watch = 1'b0;
  logic valid_prev = 1'b0;

  always @(negedge i_clk) begin
    if (o_valid) nvalid++;
    if (o_err) nerr++;
    if (o_valid && o_err) nboth++;
    if (o_valid && valid_prev) nlong++;
    valid_prev = o_valid;
    if (watch && o_busy) nbusy++;
    if (watch && o_miso) nmiso++;
  end

  typedef struct {
    logic            pre_load;
    logic [BITS-1:0] pre_val;
    int              load_at;
    logic [BITS-1:0] load_val;
    logic [BITS-1:0] mosi;
    int              rises;
    logic [BITS-1:0] exp_data;
    logic [BITS-1:0] exp_miso;
    int              exp_valid;
    int              exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [BITS-1:0] v);
    i_data = v;
    i_load = 1'b1;
    tick(1);
    i_load = 1'b0;
  endtask

  task automatic frame(input logic [BITS-1:0] word, input int rises,
                       input int load_at, input logic [BITS-1:0] load_val,
                       input int abort_at,
                       output logic [BITS-1:0] miso_w,
                       output int extra_bad, output logic busy_mid);
    miso_w = '0;
    extra_bad = 0;
    busy_mid = 1'b0;
    i_ss = 1'b0;
    i_mosi = word[BITS-1];
    tick(8);
    for (int i = 0; i < rises; i++) begin
      if (i < BITS) miso_w[BITS-1-i] = o_miso;
      else if (o_miso !== miso_w[0]) extra_bad++;
      i_sclk = 1'b1;
      tick(1);
      if (i == 0) busy_mid = o_busy;
      tick(3);
      if (i == abort_at) begin
        i_rst = 1'b0;
        #1;
        check("abort_data", 32'(o_data), 32'h0);
        check("abort_valid", 32'(o_valid), 32'h0);
        check("abort_busy", 32'(o_busy), 32'h0);
        check("abort_err", 32'(o_err), 32'h0);
        check("abort_miso", 32'(o_miso), 32'h0);
        i_ss = 1'b1;
        i_sclk = 1'b0;
        i_mosi = 1'b0;
        tick(3);
        i_rst = 1'b1;
        tick(8);
        return;
      end
      i_sclk = 1'b0;
      i_mosi = (i + 1 < BITS) ? word[BITS-2-i] : 1'b0;
      if (i == load_at) begin
        i_data = load_val;
        i_load = 1'b1;
        tick(1);
        i_load = 1'b0;
        tick(3);
      end else begin
        tick(4);
      end
    end
    tick(4);
    i_ss = 1'b1;
    tick(10);
  endtask

  initial begin
    logic [BITS-1:0] mw;
    logic [BITS-1:0] mask;
    int bad;
    logic bm;
    int nv0;
    int ne0;

    tbl[0] = '{1'b1, 20'hA5F0C, -1, 20'h0, 20'h12345, 20,
               20'h12345, 20'hA5F0C, 1, 0};
    tbl[1] = '{1'b0, 20'h0, 10, 20'h0F0F0, 20'hFFFFF, 20,
               20'hFFFFF, 20'hA5F0C, 1, 0};
    tbl[2] = '{1'b0, 20'h0, -1, 20'h0, 20'h00001, 20,
               20'h00001, 20'h0F0F0, 1, 0};
    tbl[3] = '{1'b0, 20'h0, -1, 20'h0, 20'h7F000, 7,
               20'h00001, 20'h0F0F0, 0, 1};
    tbl[4] = '{1'b1, 20'h3C3C3, -1, 20'h0, 20'hABCDE, 20,
               20'hABCDE, 20'h3C3C3, 1, 0};
    tbl[5] = '{1'b0, 20'h0, -1, 20'h0, 20'h55AA5, 23,
               20'h55AA5, 20'h3C3C3, 1, 0};

    tick(3);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    check("rst_miso", 32'(o_miso), 32'h0);
    i_rst = 1'b1;
    tick(5);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].pre_load) load(tbl[v].pre_val);
      nv0 = nvalid;
      ne0 = nerr;
      frame(tbl[v].mosi, tbl[v].rises, tbl[v].load_at, tbl[v].load_val,
            -1, mw, bad, bm);
      mask = '0;
      for (int b = 0; b < BITS && b < tbl[v].rises; b++)
        mask[BITS-1-b] = 1'b1;
      check($sformatf("v%0d_data", v), 32'(o_data), 32'(tbl[v].exp_data));
      check($sformatf("v%0d_valid", v), 32'(nvalid - nv0),
            32'(tbl[v].exp_valid));
      check($sformatf("v%0d_err", v), 32'(nerr - ne0), 32'(tbl[v].exp_err));
      check($sformatf("v%0d_miso", v), 32'(mw & mask),
            32'(tbl[v].exp_miso & mask));
      check($sformatf("v%0d_busy_mid", v), 32'(bm), 32'h1);
      check($sformatf("v%0d_busy_end", v), 32'(o_busy), 32'h0);
      check($sformatf("v%0d_miso_idle", v), 32'(o_miso), 32'h0);
      if (tbl[v].rises > BITS)
        check($sformatf("v%0d_miso_hold", v), 32'(bad), 32'h0);
    end

    load(20'h9E37A);
    nv0 = nvalid;
    ne0 = nerr;
    frame(20'h11111, 20, -1, 20'h0, 9, mw, bad, bm);
    check("abort_no_valid", 32'(nvalid - nv0), 32'h0);
    check("abort_no_err", 32'(nerr - ne0), 32'h0);
    load(20'h13579);
    nv0 = nvalid;
    frame(20'h2468A, 20, -1, 20'h0, -1, mw, bad, bm);
    check("post_rst_data", 32'(o_data), 32'h2468A);
    check("post_rst_valid", 32'(nvalid - nv0), 32'h1);
    check("post_rst_miso", 32'(mw), 32'h13579);

    nv0 = nvalid;
    ne0 = nerr;
    watch = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_sclk = ~i_sclk;
      i_mosi = k[1];
      tick(4);
    end
    i_sclk = 1'b0;
    i_mosi = 1'b0;
    tick(8);
    watch = 1'b0;
    check("idle_valid", 32'(nvalid - nv0), 32'h0);
    check("idle_err", 32'(nerr - ne0), 32'h0);
    check("idle_busy", 32'(nbusy), 32'h0);
    check("idle_miso", 32'(nmiso), 32'h0);
    check("idle_data", 32'(o_data), 32'h2468A);

    check("valid_err_overlap", 32'(nboth), 32'h0);
    check("valid_width", 32'(nlong), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
